// File: rtl/vga_sync_gen.sv
`timescale 1ns/1ps
// 640x480@60Hz VGA timing generator: free-running pixel/line counters with
// registered sync, blanking and position-pulse decodes aligned to the same pixel.
module vga_sync_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       frame_start,
   output logic       line_end
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   // Decode bounds carry an extra bit so a sync window ending at 1024 still compares correctly.
   localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
   localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
   localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

   logic        line_wrap;
   logic [9:0]  h_next;
   logic [9:0]  v_next;
   logic [10:0] h_ext;
   logic [10:0] v_ext;

   always_comb begin
      line_wrap = (pixel_x == H_LAST);
      h_next    = line_wrap ? '0 : pixel_x + 10'd1;
      v_next    = pixel_y;
      if (line_wrap) begin
         v_next = (pixel_y == V_LAST) ? '0 : pixel_y + 10'd1;
      end
      h_ext = {1'b0, h_next};
      v_ext = {1'b0, v_next};
   end

   // Reset parks the counters on the last pixel so the first edge lands on (0,0).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pixel_x     <= H_LAST;
         pixel_y     <= V_LAST;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         video_on    <= 1'b0;
         frame_start <= 1'b0;
         line_end    <= 1'b1;
      end else begin
         pixel_x     <= h_next;
         pixel_y     <= v_next;
         hsync       <= !((h_ext >= HS_START) && (h_ext < HS_END));
         vsync       <= !((v_ext >= VS_START) && (v_ext < VS_END));
         video_on    <= (h_ext < H_VIS) && (v_ext < V_VIS);
         frame_start <= (h_next == '0) && (v_next == '0);
         line_end    <= (h_next == H_LAST);
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
`timescale 1ns/1ps
// Bench for vga_sync_gen: a full-size instance and a shrunken-timing instance,
// both checked every cycle against a position-from-elapsed-clocks model.
module tb_vga_sync_gen;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       hs;
      logic       vs;
      logic       von;
      logic       fs;
      logic       le;
   } pix_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       d_hsync, d_vsync, d_video_on, d_frame_start, d_line_end;
   logic [9:0] d_pixel_x, d_pixel_y;
   logic       s_hsync, s_vsync, s_video_on, s_frame_start, s_line_end;
   logic [9:0] s_pixel_x, s_pixel_y;

   int total = 0;
   int bad   = 0;
   int edges = 0;

   vga_sync_gen u_def (
      .clk(clk), .rst_n(rst_n),
      .hsync(d_hsync), .vsync(d_vsync), .video_on(d_video_on),
      .pixel_x(d_pixel_x), .pixel_y(d_pixel_y),
      .frame_start(d_frame_start), .line_end(d_line_end)
   );

   // Small geometry: 80 clocks per line, 55 lines, 4400 clocks per frame.
   vga_sync_gen #(
      .H_VISIBLE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
      .V_VISIBLE(48), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
   ) u_small (
      .clk(clk), .rst_n(rst_n),
      .hsync(s_hsync), .vsync(s_vsync), .video_on(s_video_on),
      .pixel_x(s_pixel_x), .pixel_y(s_pixel_y),
      .frame_start(s_frame_start), .line_end(s_line_end)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edges <= 0;
      else        edges <= edges + 1;
   end

   // Clocks since release fix the raster position; every output follows from it.
   function automatic pix_t model(input int k, input int hv, input int hf, input int hs,
                                  input int hb, input int vv, input int vf, input int vs,
                                  input int vb);
      pix_t m;
      int ht, vt, p, x, y;
      ht = hv + hf + hs + hb;
      vt = vv + vf + vs + vb;
      p  = (k + ht * vt - 1) % (ht * vt);
      x  = p % ht;
      y  = p / ht;
      m.x   = 10'(x);
      m.y   = 10'(y);
      m.hs  = !(x >= hv + hf && x < hv + hf + hs);
      m.vs  = !(y >= vv + vf && y < vv + vf + vs);
      m.von = (x < hv) && (y < vv);
      m.fs  = (x == 0) && (y == 0);
      m.le  = (x == ht - 1);
      return m;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic comparePix(input string tag, input pix_t a, input pix_t e);
      checkOutput({tag, " pixel_x"},     32'(a.x),   32'(e.x));
      checkOutput({tag, " pixel_y"},     32'(a.y),   32'(e.y));
      checkOutput({tag, " hsync"},       32'(a.hs),  32'(e.hs));
      checkOutput({tag, " vsync"},       32'(a.vs),  32'(e.vs));
      checkOutput({tag, " video_on"},    32'(a.von), 32'(e.von));
      checkOutput({tag, " frame_start"}, 32'(a.fs),  32'(e.fs));
      checkOutput({tag, " line_end"},    32'(a.le),  32'(e.le));
   endtask

   always @(negedge clk) begin
      pix_t a;
      a = {d_pixel_x, d_pixel_y, d_hsync, d_vsync, d_video_on, d_frame_start, d_line_end};
      comparePix("def", a, model(edges, 640, 16, 96, 48, 480, 10, 2, 33));
      a = {s_pixel_x, s_pixel_y, s_hsync, s_vsync, s_video_on, s_frame_start, s_line_end};
      comparePix("small", a, model(edges, 64, 4, 8, 4, 48, 2, 2, 3));
   end

   // Called just after a falling edge so the change lands between clock edges.
   task automatic applyStimulus(input logic level);
      #2 rst_n = level;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, " def pixel_x"},     32'(d_pixel_x), 799);
      checkOutput({tag, " def pixel_y"},     32'(d_pixel_y), 524);
      checkOutput({tag, " def hsync"},       32'(d_hsync), 1);
      checkOutput({tag, " def vsync"},       32'(d_vsync), 1);
      checkOutput({tag, " def video_on"},    32'(d_video_on), 0);
      checkOutput({tag, " def frame_start"}, 32'(d_frame_start), 0);
      checkOutput({tag, " def line_end"},    32'(d_line_end), 1);
      checkOutput({tag, " small pixel_x"},   32'(s_pixel_x), 79);
      checkOutput({tag, " small pixel_y"},   32'(s_pixel_y), 54);
   endtask

   task automatic checkFirstPixel(input string tag);
      checkOutput({tag, " def pixel_x"},       32'(d_pixel_x), 0);
      checkOutput({tag, " def pixel_y"},       32'(d_pixel_y), 0);
      checkOutput({tag, " def frame_start"},   32'(d_frame_start), 1);
      checkOutput({tag, " def video_on"},      32'(d_video_on), 1);
      checkOutput({tag, " def line_end"},      32'(d_line_end), 0);
      checkOutput({tag, " small frame_start"}, 32'(s_frame_start), 1);
   endtask

   // Walks one full-size line from pixel 0, measuring where each decode changes.
   task automatic scanDefaultLine(input int line);
      int von_fall, hs_fall, hs_rise, hs_low, le_x, le_cnt;
      logic prev_von, prev_hs;
      von_fall = -1; hs_fall = -1; hs_rise = -1; hs_low = 0; le_x = -1; le_cnt = 0;
      prev_von = 1'b1; prev_hs = 1'b1;
      checkOutput($sformatf("line%0d start y", line), 32'(d_pixel_y), 32'(line));
      checkOutput($sformatf("line%0d start x", line), 32'(d_pixel_x), 0);
      for (int i = 0; i < 800; i++) begin
         if (prev_von && !d_video_on && von_fall < 0) von_fall = int'(d_pixel_x);
         if (prev_hs && !d_hsync && hs_fall < 0) hs_fall = int'(d_pixel_x);
         if (!prev_hs && d_hsync && hs_rise < 0) hs_rise = int'(d_pixel_x);
         if (!d_hsync) hs_low++;
         if (d_line_end) begin le_x = int'(d_pixel_x); le_cnt++; end
         prev_von = d_video_on;
         prev_hs  = d_hsync;
         @(negedge clk);
      end
      checkOutput($sformatf("line%0d video_on fall x", line), 32'(von_fall), 640);
      checkOutput($sformatf("line%0d hsync fall x", line),    32'(hs_fall), 656);
      checkOutput($sformatf("line%0d hsync rise x", line),    32'(hs_rise), 752);
      checkOutput($sformatf("line%0d hsync low clocks", line), 32'(hs_low), 96);
      checkOutput($sformatf("line%0d line_end x", line),      32'(le_x), 799);
      checkOutput($sformatf("line%0d line_end count", line),  32'(le_cnt), 1);
   endtask

   // Starts on a small-instance frame_start and runs to the next one.
   task automatic measureSmallFrame(input string tag);
      int period, lines, von, vs_low, fall_x, fall_y, rise_x, rise_y, max_y, last_x, last_y;
      logic prev_vs;
      period = 0; lines = 0; von = 0; vs_low = 0; max_y = 0; last_x = -1; last_y = -1;
      fall_x = -1; fall_y = -1; rise_x = -1; rise_y = -1;
      prev_vs = s_vsync;
      do begin
         if (s_line_end) lines++;
         if (s_video_on) von++;
         if (!s_vsync) vs_low++;
         if (prev_vs && !s_vsync) begin fall_x = int'(s_pixel_x); fall_y = int'(s_pixel_y); end
         if (!prev_vs && s_vsync) begin rise_x = int'(s_pixel_x); rise_y = int'(s_pixel_y); end
         if (int'(s_pixel_y) > max_y) max_y = int'(s_pixel_y);
         last_x  = int'(s_pixel_x);
         last_y  = int'(s_pixel_y);
         prev_vs = s_vsync;
         @(negedge clk);
         period++;
      end while (!s_frame_start && period < 10000);
      checkOutput({tag, " frame period"},     32'(period), 4400);
      checkOutput({tag, " line_end count"},   32'(lines), 55);
      checkOutput({tag, " video_on clocks"},  32'(von), 3072);
      checkOutput({tag, " vsync low clocks"}, 32'(vs_low), 160);
      checkOutput({tag, " vsync fall x"},     32'(fall_x), 0);
      checkOutput({tag, " vsync fall y"},     32'(fall_y), 50);
      checkOutput({tag, " vsync rise x"},     32'(rise_x), 0);
      checkOutput({tag, " vsync rise y"},     32'(rise_y), 52);
      checkOutput({tag, " max pixel_y"},      32'(max_y), 54);
      checkOutput({tag, " pre-wrap x"},       32'(last_x), 79);
      checkOutput({tag, " pre-wrap y"},       32'(last_y), 54);
   endtask

   initial begin
      int waited;
      repeat (5) @(negedge clk);
      checkResetValues("reset");

      applyStimulus(1'b1);
      @(negedge clk);
      checkFirstPixel("release");

      scanDefaultLine(0);
      scanDefaultLine(1);

      waited = 0;
      while (!s_frame_start && waited < 5000) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("small frame_start seen", 32'(s_frame_start), 1);
      for (int f = 0; f < 3; f++) measureSmallFrame($sformatf("frame%0d", f));

      waited = 0;
      while (d_pixel_x != 10'd300 && waited < 1000) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("reach x=300", 32'(d_pixel_x), 300);
      applyStimulus(1'b0);
      #1;
      checkResetValues("midreset");
      repeat (3) @(negedge clk);
      applyStimulus(1'b1);
      @(negedge clk);
      checkFirstPixel("rerelease");
      measureSmallFrame("after reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
